// File: rtl/sigmoid_alu_accumulator_pkg.sv
// sigmoid_ALU_pkg: shared widths and FSM state type for the sigmoid MAC stage.
package sigmoid_ALU_pkg;
  localparam int ACCUM_W = 14;
  localparam int ACT_W = 4;
  localparam int WGT_W = 4;
  localparam int PROD_W = ACT_W + 1 + WGT_W;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} accum_state_t;
endpackage

// File: rtl/sigmoid_alu_accumulator_product_adder.sv
// sigmoid_ALU_product_adder: signed activation*weight product added to the running sum.
// Saturating add when SIGMOID_ALU_ACCUM_SAT_EN is defined, otherwise 14-bit wrap.
module sigmoid_ALU_product_adder
  import sigmoid_ALU_pkg::*;
(
  input  logic        [ACT_W-1:0]   activation,
  input  logic signed [WGT_W-1:0]   weight,
  input  logic signed [ACCUM_W-1:0] accum,
  output logic signed [ACCUM_W-1:0] next_accum
);
  logic signed [PROD_W-1:0] product;
  assign product = $signed({1'b0, activation}) * weight;
`ifdef SIGMOID_ALU_ACCUM_SAT_EN
  logic signed [ACCUM_W:0] sum;
  assign sum = {accum[ACCUM_W-1], accum} + {{(ACCUM_W+1-PROD_W){product[PROD_W-1]}}, product};
  // top two bits disagree only when the true result left the 14-bit range
  assign next_accum = (sum[ACCUM_W] ^ sum[ACCUM_W-1]) ? (sum[ACCUM_W] ? 14'h2000 : 14'h1FFF) : sum[ACCUM_W-1:0];
`else
  assign next_accum = accum + {{(ACCUM_W-PROD_W){product[PROD_W-1]}}, product};
`endif
endmodule

// File: rtl/sigmoid_alu_accumulator.sv
// sigmoid_alu_accumulator: N_TERMS-pair multiply-accumulate feeding the sigmoid calculator.
// Optional saturation via SIGMOID_ALU_ACCUM_SAT_EN (see product adder).
module sigmoid_alu_accumulator
  import sigmoid_ALU_pkg::*;
#(
  parameter int N_TERMS = 784
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      data_valid,
  input  logic        [ACT_W-1:0]   activation,
  input  logic signed [WGT_W-1:0]   weight,
  output logic signed [ACCUM_W-1:0] accum,
  output logic                      accum_valid,
  output logic                      busy,
  output logic        [CNT_W-1:0]   term_count
);
  accum_state_t state, next_state;
  logic signed [ACCUM_W-1:0] next_accum;
  logic take, last;
  sigmoid_ALU_product_adder u_adder (
    .activation(activation),
    .weight(weight),
    .accum(accum),
    .next_accum(next_accum)
  );
  assign take = (state == ACCUM) && data_valid && !start;
  assign last = term_count == CNT_W'(N_TERMS - 1);
  always_comb begin
    next_state = IDLE;
    next_state = start ? ACCUM : (state == ACCUM) ? ((data_valid && last) ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      accum <= '0;
      term_count <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        accum <= '0;
        term_count <= '0;
      end else if (take) begin
        accum <= next_accum;
        term_count <= term_count + 1'b1;
      end
    end
  end
  assign busy = state == ACCUM;
  assign accum_valid = state == DONE;
endmodule

// File: tb/tb_sigmoid_alu_accumulator.sv
// tb_sigmoid_alu_accumulator: table vectors, corner sequences and randomized model check.
module tb_sigmoid_alu_accumulator;
  logic clk = 0;
  logic n_rst = 0;
  logic start = 0, data_valid = 0;
  logic [3:0] activation = 0;
  logic signed [3:0] weight = 0;
  logic signed [13:0] accum;
  logic accum_valid, busy;
  logic [9:0] term_count;
  logic start2 = 0, dv2 = 0;
  logic [3:0] act2 = 0;
  logic signed [3:0] wgt2 = 0;
  logic signed [13:0] acc2;
  logic valid2, busy2;
  logic [9:0] cnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sigmoid_alu_accumulator #(.N_TERMS(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data_valid(data_valid),
    .activation(activation), .weight(weight), .accum(accum),
    .accum_valid(accum_valid), .busy(busy), .term_count(term_count)
  );
  sigmoid_alu_accumulator #(.N_TERMS(100)) dut_ovf (
    .clk(clk), .n_rst(n_rst), .start(start2), .data_valid(dv2),
    .activation(act2), .weight(wgt2), .accum(acc2),
    .accum_valid(valid2), .busy(busy2), .term_count(cnt2)
  );

  typedef struct {
    logic s;
    logic dv;
    int a;
    int w;
    int acc;
    logic v;
    logic b;
    int cnt;
  } vec_t;
  vec_t tv[$];

  function automatic int addf(int acc, int p);
    int s = acc + p;
    int r;
`ifdef SIGMOID_ALU_ACCUM_SAT_EN
    if (s > 8191) s = 8191;
    if (s < -8192) s = -8192;
`else
    r = (s + 8192) % 16384;
    if (r < 0) r += 16384;
    s = r - 8192;
`endif
    return s;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int acc, input logic v, input logic b, input int cnt);
    check({tag, " accum"}, int'(accum), acc);
    check({tag, " valid"}, int'(accum_valid), int'(v));
    check({tag, " busy"}, int'(busy), int'(b));
    check({tag, " count"}, int'(term_count), cnt);
  endtask

  task automatic step1(input logic s, input logic dv, input int a, input int w);
    start = s;
    data_valid = dv;
    activation = 4'(a);
    weight = 4'(w);
    @(posedge clk);
    #1;
    start = 0;
    data_valid = 0;
  endtask

  task automatic step2(input logic s, input logic dv, input int a, input int w);
    start2 = s;
    dv2 = dv;
    act2 = 4'(a);
    wgt2 = 4'(w);
    @(posedge clk);
    #1;
    start2 = 0;
    dv2 = 0;
  endtask

  task automatic run_ovf(input string tag, input int w);
    int exp = 0;
    step2(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step2(0, 1, 15, w);
      exp = addf(exp, 15 * w);
    end
    check({tag, " accum"}, int'(acc2), exp);
    check({tag, " valid"}, int'(valid2), 1);
    check({tag, " busy"}, int'(busy2), 0);
    check({tag, " count"}, int'(cnt2), 100);
  endtask

  initial begin
    int m_mode, m_acc, m_cnt;
    logic s, dv;
    int a, w;
    // basic sum
    tv.push_back('{1, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 1, 8, 7, 56, 0, 1, 1});
    tv.push_back('{0, 1, 8, 7, 112, 0, 1, 2});
    tv.push_back('{0, 1, 3, -2, 106, 0, 1, 3});
    tv.push_back('{0, 1, 0, -8, 106, 1, 0, 4});
    tv.push_back('{0, 0, 0, 0, 106, 0, 0, 4});
    tv.push_back('{0, 1, 5, 5, 106, 0, 0, 4});
    // gapped input
    tv.push_back('{1, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 1, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 0, 9, 7, 1, 0, 1, 1});
    tv.push_back('{0, 0, 9, 7, 1, 0, 1, 1});
    tv.push_back('{0, 1, 2, -3, -5, 0, 1, 2});
    tv.push_back('{0, 0, 0, 0, -5, 0, 1, 2});
    tv.push_back('{0, 0, 0, 0, -5, 0, 1, 2});
    tv.push_back('{0, 1, 5, 2, 5, 0, 1, 3});
    tv.push_back('{0, 0, 0, 0, 5, 0, 1, 3});
    tv.push_back('{0, 1, 1, 0, 5, 1, 0, 4});
    tv.push_back('{0, 0, 0, 0, 5, 0, 0, 4});
    // restart with a colliding pair, then back-to-back neuron from DONE
    tv.push_back('{1, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 1, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 1, 2, 2, 5, 0, 1, 2});
    tv.push_back('{1, 1, 7, 7, 0, 0, 1, 0});
    tv.push_back('{0, 1, 1, -1, -1, 0, 1, 1});
    tv.push_back('{0, 1, 1, -1, -2, 0, 1, 2});
    tv.push_back('{0, 1, 1, -1, -3, 0, 1, 3});
    tv.push_back('{0, 1, 1, -1, -4, 1, 0, 4});
    tv.push_back('{1, 0, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 1, 15, 7, 105, 0, 1, 1});
    tv.push_back('{0, 1, 15, -8, -15, 0, 1, 2});
    tv.push_back('{0, 1, 2, 3, -9, 0, 1, 3});
    tv.push_back('{0, 1, 0, 0, -9, 1, 0, 4});
    tv.push_back('{0, 0, 0, 0, -9, 0, 0, 4});

    #2;
    check_out("reset", 0, 0, 0, 0);
    #20;
    n_rst = 1;
    @(posedge clk);
    #1;
    check_out("post_reset", 0, 0, 0, 0);
    foreach (tv[i]) begin
      step1(tv[i].s, tv[i].dv, tv[i].a, tv[i].w);
      check_out($sformatf("vec%0d", i), tv[i].acc, tv[i].v, tv[i].b, tv[i].cnt);
    end

    // asynchronous reset mid-accumulation
    step1(1, 0, 0, 0);
    step1(0, 1, 7, 7);
    step1(0, 1, 7, 7);
    check_out("pre_arst", 98, 0, 1, 2);
    #2;
    n_rst = 0;
    #1;
    check_out("arst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    n_rst = 1;
    step1(0, 1, 7, 7);
    check_out("arst_idle", 0, 0, 0, 0);

    run_ovf("ovf_pos", 7);
    run_ovf("ovf_neg", -8);

    // randomized traffic against a sequence-level model
    m_mode = 0;
    m_acc = 0;
    m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom % 12) == 0;
      dv = $urandom % 2;
      a = $urandom % 16;
      w = int'($urandom % 16) - 8;
      step1(s, dv, a, w);
      if (s) begin
        m_mode = 1;
        m_acc = 0;
        m_cnt = 0;
      end else if (m_mode == 1) begin
        if (dv) begin
          m_acc = addf(m_acc, a * w);
          m_cnt++;
          if (m_cnt == 4) m_mode = 2;
        end
      end else m_mode = 0;
      check_out($sformatf("rnd%0d", i), m_acc, m_mode == 2, m_mode == 1, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
